// File: rtl/scroll_layer_renderer.sv
// scroll_layer_renderer
// Background-layer renderer for the 640x480 VGA path. Each screen pixel
// (DrawX, DrawY) is down-scaled by 2^SCALE_SHIFT, offset by the active
// per-frame scroll with wrap-around, optionally mirrored horizontally, and
// turned into an address for an external synchronous image ROM. The returned
// palette index is resolved through a writable 12-bit palette and faded.
// The colour and the opaque flag are registered, with a fixed 4-cycle latency.
//
// Ports:
//   vga_clk, reset           pixel clock, asynchronous active-high reset
//   DrawX, DrawY, blank      pixel coordinate and active-region flag (1 = active)
//   frame_start              one-cycle pulse; promotes pending scroll set to active
//   scroll_req               loads scroll_x/scroll_y/mirror_x/fade into pending
//   scroll_x, scroll_y       scroll offsets (requests out of image range are ignored)
//   mirror_x, fade           horizontal mirror, fade level (0 full .. 3 black)
//   pal_we/pal_waddr/pal_wdata  palette write port, {R,G,B} 4 bits each
//   rom_addr, rom_q          external ROM address (registered) and data (1 cycle later)
//   red, green, blue, opaque registered pixel outputs
module scroll_layer_renderer #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int IDX_W       = 4,
  parameter int ADDR_W      = $clog2(IMG_W * IMG_H),
  parameter bit TRANSP_EN   = 1'b1,
  parameter int TRANSP_IDX  = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              scroll_req,
  input  logic [ADDR_W-1:0] scroll_x,
  input  logic [ADDR_W-1:0] scroll_y,
  input  logic              mirror_x,
  input  logic [1:0]        fade,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_waddr,
  input  logic [11:0]       pal_wdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque
);

  // One extra bit so the scaled coordinate plus offset cannot overflow.
  localparam int CW    = ADDR_W + 1;
  localparam int PAL_N = 1 << IDX_W;

  // Pending and active scroll sets
  logic [ADDR_W-1:0] px_q, px_d, py_q, py_d, ax_q, ax_d, ay_q, ay_d;
  logic              pm_q, pm_d, am_q, am_d;
  logic [1:0]        pf_q, pf_d, af_q, af_d;
  logic              req_ok;

  // Pipeline
  logic [CW-1:0]     sx_sum, sy_sum, sx_wrap, sy_wrap;
  logic [ADDR_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              blank1_q, blank2_q, blank3_q;
  // Fade travels with its pixel so a pixel is rendered with one consistent set.
  logic [1:0]        fade1_q, fade2_q, fade3_q;

  // Palette and output stage
  logic [11:0]       pal_q [PAL_N];
  logic [11:0]       pal_d [PAL_N];
  logic [11:0]       pal_rd;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              opaque_q, opaque_d;

  function automatic logic [3:0] shade(input logic [3:0] c, input logic [1:0] f);
    // A plain shift by 3 would keep the MSB; level 3 means fully black.
    return (f == 2'd3) ? 4'd0 : (c >> f);
  endfunction

  always_comb begin
    req_ok = scroll_req && (scroll_x < ADDR_W'(IMG_W)) && (scroll_y < ADDR_W'(IMG_H));
    px_d = px_q; py_d = py_q; pm_d = pm_q; pf_d = pf_q;
    ax_d = ax_q; ay_d = ay_q; am_d = am_q; af_d = af_q;
    if (req_ok) begin
      px_d = scroll_x; py_d = scroll_y; pm_d = mirror_x; pf_d = fade;
    end
    // A valid request coinciding with frame_start skips the pending stage.
    if (frame_start) begin
      if (req_ok) begin
        ax_d = scroll_x; ay_d = scroll_y; am_d = mirror_x; af_d = fade;
      end else begin
        ax_d = px_q; ay_d = py_q; am_d = pm_q; af_d = pf_q;
      end
    end
  end

  always_comb begin
    sx_sum  = CW'(DrawX >> SCALE_SHIFT) + CW'(ax_q);
    sy_sum  = CW'(DrawY >> SCALE_SHIFT) + CW'(ay_q);
    // Both terms are below the image size, so one subtraction wraps fully.
    sx_wrap = (sx_sum >= CW'(IMG_W)) ? sx_sum - CW'(IMG_W) : sx_sum;
    sy_wrap = (sy_sum >= CW'(IMG_H)) ? sy_sum - CW'(IMG_H) : sy_sum;
    sx_d    = am_q ? ADDR_W'(IMG_W - 1) - sx_wrap[ADDR_W-1:0] : sx_wrap[ADDR_W-1:0];
    sy_d    = sy_wrap[ADDR_W-1:0];
    rom_addr_d = sy_q * ADDR_W'(IMG_W) + sx_q;
  end

  always_comb begin
    pal_d = pal_q;
    if (pal_we) pal_d[pal_waddr] = pal_wdata;
    // Read uses the registered array, so a same-cycle write shows the old value.
    pal_rd   = pal_q[rom_q];
    red_d    = blank3_q ? shade(pal_rd[11:8], fade3_q) : 4'd0;
    green_d  = blank3_q ? shade(pal_rd[7:4],  fade3_q) : 4'd0;
    blue_d   = blank3_q ? shade(pal_rd[3:0],  fade3_q) : 4'd0;
    opaque_d = blank3_q && !(TRANSP_EN && (rom_q == IDX_W'(TRANSP_IDX)));
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      px_q <= '0; py_q <= '0; pm_q <= 1'b0; pf_q <= '0;
      ax_q <= '0; ay_q <= '0; am_q <= 1'b0; af_q <= '0;
      sx_q <= '0; sy_q <= '0; rom_addr_q <= '0;
      blank1_q <= 1'b0; blank2_q <= 1'b0; blank3_q <= 1'b0;
      fade1_q <= '0; fade2_q <= '0; fade3_q <= '0;
      red_q <= '0; green_q <= '0; blue_q <= '0; opaque_q <= 1'b0;
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= '0;
    end else begin
      px_q <= px_d; py_q <= py_d; pm_q <= pm_d; pf_q <= pf_d;
      ax_q <= ax_d; ay_q <= ay_d; am_q <= am_d; af_q <= af_d;
      sx_q <= sx_d; sy_q <= sy_d; rom_addr_q <= rom_addr_d;
      blank1_q <= blank; blank2_q <= blank1_q; blank3_q <= blank2_q;
      fade1_q <= af_q; fade2_q <= fade1_q; fade3_q <= fade2_q;
      red_q <= red_d; green_q <= green_d; blue_q <= blue_d; opaque_q <= opaque_d;
      pal_q <= pal_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign opaque   = opaque_q;

endmodule

// File: tb/tb_scroll_layer_renderer.sv
// tb_scroll_layer_renderer
// Self-checking bench for scroll_layer_renderer. Holds the image ROM, drives
// directed and randomized pixel streams, and compares every cycle against a
// pixel-level reference model (queue of in-flight pixels, plain arithmetic).
module tb_scroll_layer_renderer;

  localparam int IMG_W       = 160;
  localparam int IMG_H       = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int IDX_W       = 4;
  localparam int ADDR_W      = $clog2(IMG_W * IMG_H);
  localparam int TRANSP_IDX  = 0;

  logic              vga_clk, reset;
  logic [9:0]        DrawX, DrawY;
  logic              blank, frame_start, scroll_req, mirror_x, pal_we;
  logic [ADDR_W-1:0] scroll_x, scroll_y, rom_addr;
  logic [1:0]        fade;
  logic [IDX_W-1:0]  pal_waddr, rom_q;
  logic [11:0]       pal_wdata;
  logic [3:0]        red, green, blue;
  logic              opaque;

  scroll_layer_renderer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(SCALE_SHIFT), .IDX_W(IDX_W),
    .ADDR_W(ADDR_W), .TRANSP_EN(1'b1), .TRANSP_IDX(TRANSP_IDX)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .scroll_req(scroll_req),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .mirror_x(mirror_x), .fade(fade),
    .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .red(red), .green(green), .blue(blue), .opaque(opaque)
  );

  // Clock and external synchronous image ROM
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [IDX_W-1:0] rom_mem [IMG_W*IMG_H];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  // Reference model state
  typedef struct { int idx; int f; bit blank; } pix_t;
  pix_t        pipe_q[$];
  logic [11:0] m_pal [16];
  int pend_x, pend_y, pend_m, pend_f;
  int act_x, act_y, act_m, act_f;
  int last_addr;
  int numChecked = 0;
  int numFailed  = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numChecked++;
    if (observed != expected) begin
      numFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    pix_t z;
    z.idx = 0; z.f = 0; z.blank = 1'b0;
    pipe_q.delete();
    repeat (3) pipe_q.push_back(z);
    last_addr = 0;
    pend_x = 0; pend_y = 0; pend_m = 0; pend_f = 0;
    act_x = 0; act_y = 0; act_m = 0; act_f = 0;
    for (int i = 0; i < 16; i++) m_pal[i] = 12'h000;
  endtask

  function automatic int modelAddr(input int x, input int y);
    int sx, sy;
    sx = ((x >> SCALE_SHIFT) + act_x) % IMG_W;
    if (act_m != 0) sx = IMG_W - 1 - sx;
    sy = ((y >> SCALE_SHIFT) + act_y) % IMG_H;
    return sy * IMG_W + sx;
  endfunction

  function automatic int shadeModel(input int c, input int f);
    return (f == 3) ? 0 : c / (1 << f);
  endfunction

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic applyStimulus(input int x, input int y, input bit bl, input bit fs,
                               input bit sreq, input int sxv, input int syv,
                               input bit mir, input int fd, input bit we,
                               input int wa, input int wd);
    pix_t rec, outp;
    int addr, exp_addr, er, eg, eb, eo;
    logic [11:0] pe;
    bit ok;
    DrawX = 10'(x); DrawY = 10'(y); blank = bl; frame_start = fs;
    scroll_req = sreq; scroll_x = ADDR_W'(sxv); scroll_y = ADDR_W'(syv);
    mirror_x = mir; fade = 2'(fd); pal_we = we; pal_waddr = IDX_W'(wa); pal_wdata = 12'(wd);
    addr = modelAddr(x, y);
    rec.idx = int'(rom_mem[addr]); rec.f = act_f; rec.blank = bl;
    pipe_q.push_back(rec);
    exp_addr = last_addr;
    last_addr = addr;
    outp = pipe_q.pop_front();
    er = 0; eg = 0; eb = 0; eo = 0;
    if (outp.blank) begin
      pe = m_pal[outp.idx];
      er = shadeModel(int'(pe[11:8]), outp.f);
      eg = shadeModel(int'(pe[7:4]), outp.f);
      eb = shadeModel(int'(pe[3:0]), outp.f);
      eo = (outp.idx != TRANSP_IDX) ? 1 : 0;
    end
    if (we) m_pal[wa] = 12'(wd);
    ok = sreq && (sxv < IMG_W) && (syv < IMG_H);
    if (fs) begin
      if (ok) begin act_x = sxv; act_y = syv; act_m = mir; act_f = fd; end
      else begin act_x = pend_x; act_y = pend_y; act_m = pend_m; act_f = pend_f; end
    end
    if (ok) begin pend_x = sxv; pend_y = syv; pend_m = mir; pend_f = fd; end
    @(posedge vga_clk);
    #1;
    checkOutput("rom_addr", int'(rom_addr), exp_addr);
    checkOutput("red", int'(red), er);
    checkOutput("green", int'(green), eg);
    checkOutput("blue", int'(blue), eb);
    checkOutput("opaque", int'(opaque), eo);
  endtask

  task automatic pixel(input int x, input int y, input bit bl);
    applyStimulus(x, y, bl, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pixel(0, 0, 0);
  endtask

  // Flush in-flight pixels, then apply a request together with frame_start.
  task automatic setScroll(input int sxv, input int syv, input bit mir, input int fd);
    idle(3);
    applyStimulus(0, 0, 0, 1, 1, sxv, syv, mir, fd, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    DrawX = '0; DrawY = '0; blank = 0; frame_start = 0; scroll_req = 0;
    scroll_x = '0; scroll_y = '0; mirror_x = 0; fade = '0;
    pal_we = 0; pal_waddr = '0; pal_wdata = '0;
    for (int i = 0; i < IMG_W * IMG_H; i++) rom_mem[i] = IDX_W'($urandom);
    rom_mem[0] = 4'd5; rom_mem[1] = 4'd0; rom_mem[159] = 4'd3;
    rom_mem[162] = 4'd3; rom_mem[15989] = 4'd3;

    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge vga_clk);
    #1;
    checkOutput("reset_rom_addr", int'(rom_addr), 0);
    checkOutput("reset_red", int'(red), 0);
    checkOutput("reset_opaque", int'(opaque), 0);
    reset = 1'b0;

    $display("[TB] loading palette");
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, i,
                    (i == 3) ? 12'hF84 : (i == 0) ? 12'h5A3 : int'($urandom_range(0, 4095)));

    $display("[TB] default mapping");
    pixel(8, 4, 1);
    idle(1);
    checkOutput("addr_8_4", int'(rom_addr), 162);
    idle(2);
    checkOutput("def_red", int'(red), 15);
    checkOutput("def_green", int'(green), 8);
    checkOutput("def_blue", int'(blue), 4);

    $display("[TB] wrap-around");
    setScroll(150, 100, 0, 0);
    pixel(639, 479, 1);
    idle(1);
    checkOutput("addr_wrap", int'(rom_addr), 15989);
    idle(2);

    $display("[TB] mirror and fade");
    setScroll(0, 0, 1, 1);
    pixel(0, 0, 1);
    idle(3);
    checkOutput("fade1_red", int'(red), 7);
    checkOutput("fade1_green", int'(green), 4);
    checkOutput("fade1_blue", int'(blue), 2);
    setScroll(0, 0, 1, 3);
    pixel(0, 0, 1);
    idle(3);
    checkOutput("fade3_red", int'(red), 0);
    checkOutput("fade3_opaque", int'(opaque), 1);

    $display("[TB] control update timing");
    setScroll(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 40, 0, 0, 0, 0, 0, 0);
    pixel(0, 0, 0);
    idle(1);
    checkOutput("midframe_hold", int'(rom_addr), 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    pixel(0, 0, 0);
    idle(1);
    checkOutput("frame_apply", int'(rom_addr), 40);
    applyStimulus(0, 0, 0, 1, 1, 160, 5, 0, 0, 0, 0, 0);
    pixel(0, 0, 0);
    idle(1);
    checkOutput("reject_160", int'(rom_addr), 40);

    $display("[TB] transparency");
    setScroll(0, 0, 0, 0);
    pixel(4, 0, 1);
    idle(3);
    checkOutput("transp_opaque", int'(opaque), 0);
    checkOutput("transp_red", int'(red), 5);

    $display("[TB] reset mid-frame");
    repeat (4) pixel(8, 4, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_red", int'(red), 0);
    checkOutput("midrst_green", int'(green), 0);
    checkOutput("midrst_blue", int'(blue), 0);
    checkOutput("midrst_opaque", int'(opaque), 0);
    checkOutput("midrst_rom_addr", int'(rom_addr), 0);
    modelReset();
    #1;
    reset = 1'b0;
    pixel(0, 0, 1);
    idle(3);
    checkOutput("pal5_red", int'(red), 0);
    checkOutput("pal5_blue", int'(blue), 0);
    checkOutput("pal5_opaque", int'(opaque), 1);

    $display("[TB] randomized frames");
    for (int c = 0; c < 800; c++) begin
      int phase;
      bit bl, fs;
      phase = c % 16;
      fs = (phase == 15);
      bl = (phase < 12) && ($urandom_range(0, 7) != 0);
      applyStimulus(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), bl, fs,
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 179)),
                    int'($urandom_range(0, 129)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecked, numFailed);
    $finish;
  end

endmodule
